// File: rtl/prio_irq_encoder_if.sv
// Request/grant bundle between interrupt sources and the priority encoder.
// Active-low request, enable and grant signals keep the legacy 74x148 sense.
interface prio_irq_encoder_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         EI;
    logic [N-1:0] DataIn;
    logic [N-1:0] MaskIn;
    logic         MaskWe;
    logic         Ack;
    logic [W-1:0] DataOut;
    logic         GS;
    logic         EO;
    logic         Lost;

    modport master (
        output EI, DataIn, MaskIn, MaskWe, Ack,
        input  DataOut, GS, EO, Lost
    );

    modport slave (
        input  EI, DataIn, MaskIn, MaskWe, Ack,
        output DataOut, GS, EO, Lost
    );
endinterface

// File: rtl/prio_irq_encoder.sv
// Edge-latched, maskable priority/round-robin interrupt encoder with held grant.
// Fall at edge k is pending at k and granted after k+1; grant holds until Ack.
module prio_irq_encoder #(
    parameter int N    = 8,
    parameter int W    = 3,
    parameter int MODE = 0
) (
    input  logic              CLK,
    input  logic              nRST,
    prio_irq_encoder_if.slave irq
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] req_q, pend_q, pend_d, mask_q;
    logic [W-1:0] rr_q, rr_d, idx_q, idx_d;
    logic [W-1:0] dout_q, dout_d;
    logic         gs_q, gs_d, eo_q, eo_d, lost_q, lost_d;

    logic [N-1:0] fall, cand, clr;
    logic [W-1:0] sel_idx;
    logic         sel_vld;

    assign fall = req_q & ~irq.DataIn;
    assign cand = pend_q & ~mask_q;

    // Round-robin scans downward from rr_q+N-1 so the last hit is the first at/above rr_q.
    always_comb begin
        int j;
        j       = 0;
        sel_vld = 1'b0;
        sel_idx = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (cand[i]) begin
                    sel_vld = 1'b1;
                    sel_idx = W'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                j = (int'(rr_q) + k) % N;
                if (cand[j]) begin
                    sel_vld = 1'b1;
                    sel_idx = W'(j);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        gs_d    = gs_q;
        eo_d    = eo_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        clr     = '0;
        if (irq.EI) begin
            state_d = IDLE;
            dout_d  = '1;
            gs_d    = 1'b1;
            eo_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        idx_d   = sel_idx;
                        dout_d  = ~sel_idx;
                        gs_d    = 1'b0;
                        eo_d    = 1'b1;
                        state_d = GRANT;
                    end else begin
                        dout_d  = '1;
                        gs_d    = 1'b1;
                        eo_d    = 1'b0;
                    end
                end
                GRANT: begin
                    if (irq.Ack) begin
                        clr[idx_q] = 1'b1;
                        dout_d     = '1;
                        gs_d       = 1'b1;
                        eo_d       = 1'b1;
                        rr_d       = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A new fall wins over the Ack clear; a fall that re-arms the acked channel is not lost.
    assign pend_d = (pend_q & ~clr) | fall;
    assign lost_d = |(fall & pend_q & ~clr);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            req_q   <= '1;
            pend_q  <= '0;
            mask_q  <= '0;
            rr_q    <= '0;
            idx_q   <= '0;
            state_q <= IDLE;
            dout_q  <= '1;
            gs_q    <= 1'b1;
            eo_q    <= 1'b1;
            lost_q  <= 1'b0;
        end else begin
            req_q   <= irq.DataIn;
            pend_q  <= pend_d;
            if (irq.MaskWe) begin
                mask_q <= irq.MaskIn;
            end
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            dout_q  <= dout_d;
            gs_q    <= gs_d;
            eo_q    <= eo_d;
            lost_q  <= lost_d;
        end
    end

    assign irq.DataOut = dout_q;
    assign irq.GS      = gs_q;
    assign irq.EO      = eo_q;
    assign irq.Lost    = lost_q;
endmodule

// File: tb/tb_prio_irq_encoder.sv
// Bench for prio_irq_encoder: dut0 fixed priority, dut1 round-robin, shared clock/reset.
module tb_prio_irq_encoder;
    logic CLK;
    logic nRST;
    int   checks;
    int   failures;
    int   exp0[$];
    int   exp1[$];

    prio_irq_encoder_if #(.N(8), .W(3)) if0 ();
    prio_irq_encoder_if #(.N(8), .W(3)) if1 ();

    prio_irq_encoder #(.N(8), .W(3), .MODE(0)) dut0 (.CLK(CLK), .nRST(nRST), .irq(if0.slave));
    prio_irq_encoder #(.N(8), .W(3), .MODE(1)) dut1 (.CLK(CLK), .nRST(nRST), .irq(if1.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_gs0(input int which, input int budget, output bit ok,
                            output logic [2:0] code, output int cycles);
        ok = 1'b0;
        code = 3'b111;
        cycles = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            cycles++;
            if (which == 0 && if0.GS === 1'b0) begin
                ok = 1'b1;
                code = if0.DataOut;
            end else if (which == 1 && if1.GS === 1'b0) begin
                ok = 1'b1;
                code = if1.DataOut;
            end
        end
    endtask

    function automatic logic [2:0] enc(input int ch);
        logic [2:0] c;
        c = 3'(ch);
        return ~c;
    endfunction

    task automatic test_reset();
        nRST = 1'b0;
        tick();
        tick();
        checks++; if (if0.DataOut !== 3'b111) begin failures++; $display("FAIL reset_dout got=%b exp=111", if0.DataOut); end
        checks++; if (if0.GS !== 1'b1) begin failures++; $display("FAIL reset_gs got=%b exp=1", if0.GS); end
        checks++; if (if0.EO !== 1'b1) begin failures++; $display("FAIL reset_eo got=%b exp=1", if0.EO); end
        checks++; if (if0.Lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%b exp=0", if0.Lost); end
        checks++; if (if1.GS !== 1'b1 || if1.DataOut !== 3'b111) begin failures++; $display("FAIL reset_rr gs=%b dout=%b exp 1/111", if1.GS, if1.DataOut); end
        nRST = 1'b1;
        if0.EI = 1'b0;
        if1.EI = 1'b0;
        tick();
        checks++; if (if0.EO !== 1'b0) begin failures++; $display("FAIL reset_eo_enabled got=%b exp=0", if0.EO); end
        checks++; if (if1.EO !== 1'b0) begin failures++; $display("FAIL reset_eo_enabled_rr got=%b exp=0", if1.EO); end
    endtask

    task automatic test_fixed_priority();
        bit ok; logic [2:0] code; int cyc; int e;
        if0.DataIn = 8'hDB;
        exp0.push_back(5);
        exp0.push_back(2);
        tick();
        if0.DataIn = 8'hFF;
        checks++; if (if0.GS !== 1'b1) begin failures++; $display("FAIL fp_latency_gs got=%b exp=1", if0.GS); end
        wait_gs0(0, 4, ok, code, cyc);
        e = (exp0.size() > 0) ? exp0.pop_front() : -1;
        checks++; if (!ok || code !== enc(e) || cyc != 1) begin failures++; $display("FAIL fp_first ok=%0d code=%b cyc=%0d exp code=%b cyc=1", ok, code, cyc, enc(e)); end
        if0.Ack = 1'b1; tick(); if0.Ack = 1'b0;
        checks++; if (if0.GS !== 1'b1) begin failures++; $display("FAIL fp_idle_gap gs=%b exp=1", if0.GS); end
        wait_gs0(0, 4, ok, code, cyc);
        e = (exp0.size() > 0) ? exp0.pop_front() : -1;
        checks++; if (!ok || code !== enc(e) || cyc != 1) begin failures++; $display("FAIL fp_second ok=%0d code=%b cyc=%0d exp code=%b cyc=1", ok, code, cyc, enc(e)); end
        if0.Ack = 1'b1; tick(); if0.Ack = 1'b0;
        tick();
        checks++; if (if0.EO !== 1'b0 || if0.GS !== 1'b1) begin failures++; $display("FAIL fp_drained eo=%b gs=%b exp eo=0 gs=1", if0.EO, if0.GS); end
    endtask

    task automatic test_round_robin();
        bit ok; logic [2:0] code; int cyc; int e;
        if1.DataIn = 8'hBD;
        exp1.push_back(1);
        exp1.push_back(6);
        tick();
        if1.DataIn = 8'hFF;
        for (int n = 0; n < 2; n++) begin
            wait_gs0(1, 4, ok, code, cyc);
            e = (exp1.size() > 0) ? exp1.pop_front() : -1;
            checks++; if (!ok || code !== enc(e)) begin failures++; $display("FAIL rr_grant%0d ok=%0d code=%b exp=%b", n, ok, code, enc(e)); end
            if1.Ack = 1'b1; tick(); if1.Ack = 1'b0;
        end
        if1.DataIn = 8'hFD;
        exp1.push_back(1);
        tick();
        if1.DataIn = 8'hFF;
        wait_gs0(1, 4, ok, code, cyc);
        e = (exp1.size() > 0) ? exp1.pop_front() : -1;
        checks++; if (!ok || code !== enc(e)) begin failures++; $display("FAIL rr_wrap ok=%0d code=%b exp=%b", ok, code, enc(e)); end
        if1.Ack = 1'b1; tick(); if1.Ack = 1'b0;
    endtask

    task automatic test_mask_enable();
        bit ok; logic [2:0] code; int cyc; int e;
        if0.MaskIn = 8'h20; if0.MaskWe = 1'b1; tick(); if0.MaskWe = 1'b0;
        if0.DataIn = 8'hDF; tick(); if0.DataIn = 8'hFF;
        tick(); tick();
        checks++; if (if0.GS !== 1'b1 || if0.EO !== 1'b0) begin failures++; $display("FAIL mask_block gs=%b eo=%b exp gs=1 eo=0", if0.GS, if0.EO); end
        if0.MaskIn = 8'h00; if0.MaskWe = 1'b1; tick(); if0.MaskWe = 1'b0;
        exp0.push_back(5);
        wait_gs0(0, 4, ok, code, cyc);
        e = (exp0.size() > 0) ? exp0.pop_front() : -1;
        checks++; if (!ok || code !== enc(e)) begin failures++; $display("FAIL mask_cleared ok=%0d code=%b exp=%b", ok, code, enc(e)); end
        if0.EI = 1'b1; tick();
        checks++; if (if0.GS !== 1'b1 || if0.DataOut !== 3'b111 || if0.EO !== 1'b1) begin failures++; $display("FAIL ei_withdraw gs=%b dout=%b eo=%b exp 1/111/1", if0.GS, if0.DataOut, if0.EO); end
        if0.EI = 1'b0;
        exp0.push_back(5);
        wait_gs0(0, 4, ok, code, cyc);
        e = (exp0.size() > 0) ? exp0.pop_front() : -1;
        checks++; if (!ok || code !== enc(e) || cyc != 1) begin failures++; $display("FAIL ei_regrant ok=%0d code=%b cyc=%0d exp code=%b cyc=1", ok, code, cyc, enc(e)); end
        if0.Ack = 1'b1; tick(); if0.Ack = 1'b0;
        tick();
    endtask

    task automatic test_collisions();
        bit ok; logic [2:0] code; int cyc; int e;
        if0.DataIn = 8'hF7;
        exp0.push_back(3);
        tick();
        if0.DataIn = 8'hFF;
        wait_gs0(0, 4, ok, code, cyc);
        e = (exp0.size() > 0) ? exp0.pop_front() : -1;
        checks++; if (!ok || code !== enc(e)) begin failures++; $display("FAIL col_first ok=%0d code=%b exp=%b", ok, code, enc(e)); end
        if0.DataIn = 8'hF7; tick(); if0.DataIn = 8'hFF;
        checks++; if (if0.Lost !== 1'b1) begin failures++; $display("FAIL lost_pulse got=%b exp=1", if0.Lost); end
        tick();
        checks++; if (if0.Lost !== 1'b0 || if0.GS !== 1'b0 || if0.DataOut !== enc(3)) begin failures++; $display("FAIL lost_once lost=%b gs=%b dout=%b exp 0/0/%b", if0.Lost, if0.GS, if0.DataOut, enc(3)); end
        if0.DataIn = 8'hF7; if0.Ack = 1'b1;
        exp0.push_back(3);
        tick();
        if0.DataIn = 8'hFF; if0.Ack = 1'b0;
        checks++; if (if0.GS !== 1'b1) begin failures++; $display("FAIL ack_fall_idle gs=%b exp=1", if0.GS); end
        wait_gs0(0, 4, ok, code, cyc);
        e = (exp0.size() > 0) ? exp0.pop_front() : -1;
        checks++; if (!ok || code !== enc(e) || cyc != 1) begin failures++; $display("FAIL ack_fall_regrant ok=%0d code=%b cyc=%0d exp code=%b cyc=1", ok, code, cyc, enc(e)); end
        if0.Ack = 1'b1; tick(); if0.Ack = 1'b0;
        tick();
        if0.MaskIn = 8'h08; if0.MaskWe = 1'b1; tick(); if0.MaskWe = 1'b0;
        if0.DataIn = 8'hF7; tick(); if0.DataIn = 8'hFF;
        if0.Ack = 1'b1; tick(); tick(); if0.Ack = 1'b0;
        checks++; if (if0.GS !== 1'b1 || if0.EO !== 1'b0 || if0.DataOut !== 3'b111) begin failures++; $display("FAIL ack_idle gs=%b eo=%b dout=%b exp 1/0/111", if0.GS, if0.EO, if0.DataOut); end
        if0.MaskIn = 8'h00; if0.MaskWe = 1'b1; tick(); if0.MaskWe = 1'b0;
        exp0.push_back(3);
        wait_gs0(0, 4, ok, code, cyc);
        e = (exp0.size() > 0) ? exp0.pop_front() : -1;
        checks++; if (!ok || code !== enc(e)) begin failures++; $display("FAIL ack_idle_kept ok=%0d code=%b exp=%b", ok, code, enc(e)); end
        if0.Ack = 1'b1; tick(); if0.Ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        bit ok; logic [2:0] code; int cyc; int e;
        if0.DataIn = 8'hBD;
        exp0.push_back(6);
        tick();
        if0.DataIn = 8'hFF;
        wait_gs0(0, 4, ok, code, cyc);
        e = (exp0.size() > 0) ? exp0.pop_front() : -1;
        checks++; if (!ok || code !== enc(e)) begin failures++; $display("FAIL rst_pre_grant ok=%0d code=%b exp=%b", ok, code, enc(e)); end
        nRST = 1'b0; tick(); tick(); nRST = 1'b1;
        tick(); tick(); tick();
        checks++; if (if0.GS !== 1'b1 || if0.EO !== 1'b0) begin failures++; $display("FAIL rst_pending_lost gs=%b eo=%b exp gs=1 eo=0", if0.GS, if0.EO); end
        checks++; if (exp0.size() != 0 || exp1.size() != 0) begin failures++; $display("FAIL scoreboard_left q0=%0d q1=%0d exp 0/0", exp0.size(), exp1.size()); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        nRST = 1'b0;
        if0.EI = 1'b1; if0.DataIn = 8'hFF; if0.MaskIn = 8'h00; if0.MaskWe = 1'b0; if0.Ack = 1'b0;
        if1.EI = 1'b1; if1.DataIn = 8'hFF; if1.MaskIn = 8'h00; if1.MaskWe = 1'b0; if1.Ack = 1'b0;
        @(negedge CLK);
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_mask_enable();
        test_collisions();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
